// File: rtl/lzrw1_stream_unpacker_pkg.sv
// rtl/lzrw1_stream_unpacker_pkg.sv - shared types and constants for the LZRW1 stream unpacker
// Purpose: FSM state encoding, control-byte geometry, item kind encoding and
//          the registered item record presented to the decompressor.
// Ports:   none (package).
package lzrw1_pkg;

  typedef enum logic [2:0] {
    S_CTRL,
    S_BYTE0,
    S_BYTE1,
    S_PRESENT,
    S_GAP
  } state_t;

  localparam int   CTRL_BITS = 8;
  localparam logic LITERAL   = 1'b0;
  localparam logic COPY      = 1'b1;

  typedef struct packed {
    logic [15:0] data;
    logic        is_copy;
    logic        last;
  } item_t;

endpackage

// File: rtl/lzrw1_stream_unpacker_if.sv
// rtl/lzrw1_stream_unpacker_if.sv - byte-in / item-out handshake bundle for the unpacker
// Purpose: groups the compressed byte stream and the decompressor item port.
// Ports (signals):
//   in_byte/in_valid/in_last/in_ready         compressed byte stream
//   data_out/control_bit_out/data_out_valid/
//   data_out_last/decompressor_busy           item handoff to the decompressor
// Modports: master = unpacker side, slave = byte source + decompressor side.
interface lzrw1_stream_unpacker_if;

  logic [7:0]  in_byte;
  logic        in_valid;
  logic        in_last;
  logic        in_ready;
  logic [15:0] data_out;
  logic        control_bit_out;
  logic        data_out_valid;
  logic        data_out_last;
  logic        decompressor_busy;

  modport master (
    input  in_byte, in_valid, in_last, decompressor_busy,
    output in_ready, data_out, control_bit_out, data_out_valid, data_out_last
  );

  modport slave (
    output in_byte, in_valid, in_last, decompressor_busy,
    input  in_ready, data_out, control_bit_out, data_out_valid, data_out_last
  );

endinterface

// File: rtl/lzrw1_stream_unpacker.sv
// rtl/lzrw1_stream_unpacker.sv - splits an LZRW1 byte stream into literal/copy items
// Purpose: consumes control bytes and their up-to-8 items, presents each item
//          as a registered {data, control bit, last} triple paced by decompressor_busy.
// Ports:
//   clock          rising-edge clock
//   reset          asynchronous active-low reset
//   bus            master side of lzrw1_stream_unpacker_if (byte in, item out)
//   frame_done     one-cycle pulse when a frame has been fully handled
//   format_error   sticky: frame ended on the first byte of a copy token
//   items_emitted  saturating count of items accepted by the decompressor
module lzrw1_stream_unpacker
  import lzrw1_pkg::*;
#(
  parameter int ITEM_COUNT_WIDTH = 16,
  parameter bit COPY_MSB_FIRST   = 1'b1
) (
  input  logic                        clock,
  input  logic                        reset,
  lzrw1_stream_unpacker_if.master     bus,
  output logic                        frame_done,
  output logic                        format_error,
  output logic [ITEM_COUNT_WIDTH-1:0] items_emitted
);

  state_t      state;
  logic [2:0]  bit_idx;
  logic [7:0]  ctrl_sr;    // control byte, shifted left so bit 7 is always the current item
  logic [7:0]  hold_byte;  // first byte of a copy token
  item_t       item_q;
  logic        in_ready_q;
  logic        valid_q;
  logic        xfer;

  assign xfer                = bus.in_valid & in_ready_q;
  assign bus.in_ready        = in_ready_q;
  assign bus.data_out        = item_q.data;
  assign bus.control_bit_out = item_q.is_copy;
  assign bus.data_out_last   = item_q.last;
  assign bus.data_out_valid  = valid_q;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state         <= S_CTRL;
      bit_idx       <= 3'd0;
      ctrl_sr       <= 8'h00;
      hold_byte     <= 8'h00;
      item_q        <= '0;
      in_ready_q    <= 1'b0;
      valid_q       <= 1'b0;
      frame_done    <= 1'b0;
      format_error  <= 1'b0;
      items_emitted <= '0;
    end else begin
      frame_done <= 1'b0;
      case (state)
        S_CTRL: begin
          // in_ready comes up one cycle after reset release
          in_ready_q <= 1'b1;
          if (xfer) begin
            if (bus.in_last) begin
              frame_done <= 1'b1;
            end else begin
              ctrl_sr <= bus.in_byte;
              bit_idx <= 3'd0;
              state   <= S_BYTE0;
            end
          end
        end
        S_BYTE0: begin
          if (xfer) begin
            if (ctrl_sr[7] == LITERAL) begin
              item_q     <= '{data: {8'h00, bus.in_byte}, is_copy: LITERAL, last: bus.in_last};
              valid_q    <= 1'b1;
              in_ready_q <= 1'b0;
              state      <= S_PRESENT;
            end else if (bus.in_last) begin
              // truncated copy token: drop it and close the frame
              format_error <= 1'b1;
              frame_done   <= 1'b1;
              state        <= S_CTRL;
            end else begin
              hold_byte <= bus.in_byte;
              state     <= S_BYTE1;
            end
          end
        end
        S_BYTE1: begin
          if (xfer) begin
            item_q.data    <= COPY_MSB_FIRST ? {hold_byte, bus.in_byte} : {bus.in_byte, hold_byte};
            item_q.is_copy <= COPY;
            item_q.last    <= bus.in_last;
            valid_q        <= 1'b1;
            in_ready_q     <= 1'b0;
            state          <= S_PRESENT;
          end
        end
        S_PRESENT: begin
          if (!bus.decompressor_busy) begin
            valid_q <= 1'b0;
            if (items_emitted != '1) begin
              items_emitted <= items_emitted + ITEM_COUNT_WIDTH'(1);
            end
            frame_done <= item_q.last;
            state      <= S_GAP;
          end
        end
        S_GAP: begin
          // one idle cycle lets the decompressor raise busy before the next item
          in_ready_q  <= 1'b1;
          item_q.last <= 1'b0;
          if (item_q.last || bit_idx == 3'(CTRL_BITS - 1)) begin
            state <= S_CTRL;
          end else begin
            bit_idx <= bit_idx + 3'd1;
            ctrl_sr <= {ctrl_sr[6:0], 1'b0};
            state   <= S_BYTE0;
          end
        end
        default: begin
          state      <= S_CTRL;
          in_ready_q <= 1'b0;
          valid_q    <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_lzrw1_stream_unpacker.sv
// tb/tb_lzrw1_stream_unpacker.sv - directed table-driven bench for lzrw1_stream_unpacker
module tb_lzrw1_stream_unpacker;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        frame_done0, format_error0, frame_done1, format_error1;
  logic [15:0] items0, items1;
  int          total = 0;
  int          bad = 0;
  int          fd_cnt = 0;

  typedef struct {
    logic [7:0]  b;
    logic        last;
    logic        has_item;
    logic [15:0] exp_data;
    logic        exp_copy;
    logic        exp_last;
  } vec_t;

  vec_t vecs[$];

  lzrw1_stream_unpacker_if bus0 ();
  lzrw1_stream_unpacker_if bus1 ();

  assign bus1.in_byte           = bus0.in_byte;
  assign bus1.in_valid          = bus0.in_valid;
  assign bus1.in_last           = bus0.in_last;
  assign bus1.decompressor_busy = bus0.decompressor_busy;

  lzrw1_stream_unpacker #(.ITEM_COUNT_WIDTH(16), .COPY_MSB_FIRST(1'b1)) dut0 (
    .clock(clock), .reset(reset), .bus(bus0),
    .frame_done(frame_done0), .format_error(format_error0), .items_emitted(items0)
  );

  lzrw1_stream_unpacker #(.ITEM_COUNT_WIDTH(16), .COPY_MSB_FIRST(1'b0)) dut1 (
    .clock(clock), .reset(reset), .bus(bus1),
    .frame_done(frame_done1), .format_error(format_error1), .items_emitted(items1)
  );

  always #5 clock = ~clock;

  always @(negedge clock) if (frame_done0) fd_cnt <= fd_cnt + 1;

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1);
  end

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h required=%h", nm, act, exp);
    end
  endtask

  task automatic add(input logic [7:0] b, input logic last, input logic has,
                     input logic [15:0] d, input logic c, input logic l);
    vec_t v;
    v.b = b; v.last = last; v.has_item = has; v.exp_data = d; v.exp_copy = c; v.exp_last = l;
    vecs.push_back(v);
  endtask

  task automatic send(input logic [7:0] b, input logic last);
    int cnt = 0;
    @(negedge clock);
    while (!bus0.in_ready && cnt < 20) begin
      @(negedge clock);
      cnt++;
    end
    if (!bus0.in_ready) check("send_ready_timeout", 32'd0, 32'd1);
    bus0.in_byte  = b;
    bus0.in_last  = last;
    bus0.in_valid = 1'b1;
    @(posedge clock);
    #1;
    bus0.in_valid = 1'b0;
    bus0.in_last  = 1'b0;
  endtask

  task automatic get_item(input logic [15:0] d, input logic c, input logic l,
                          input string nm, output int wait_cycles);
    int cnt = 0;
    logic [15:0] d1;
    d1 = c ? {d[7:0], d[15:8]} : d;
    @(negedge clock);
    while (!bus0.data_out_valid && cnt < 20) begin
      @(negedge clock);
      cnt++;
    end
    wait_cycles = cnt;
    check({nm, "_valid"}, 32'(bus0.data_out_valid), 32'd1);
    check({nm, "_data"}, 32'(bus0.data_out), 32'(d));
    check({nm, "_ctrl"}, 32'(bus0.control_bit_out), 32'(c));
    check({nm, "_last"}, 32'(bus0.data_out_last), 32'(l));
    check({nm, "_data_lsbfirst"}, 32'(bus1.data_out), 32'(d1));
  endtask

  initial begin
    int wc;
    bus0.in_byte = 8'h00;
    bus0.in_valid = 1'b0;
    bus0.in_last = 1'b0;
    bus0.decompressor_busy = 1'b0;

    // frame 1: eight literals "a".."h"
    add(8'h00, 0, 0, 16'h0, 0, 0);
    for (int i = 0; i < 8; i++)
      add(8'h61 + 8'(i), (i == 7), 1, 16'h0061 + 16'(i), 0, (i == 7));
    // frame 2: literal then copy, remaining control bits ignored
    add(8'h40, 0, 0, 16'h0, 0, 0);
    add(8'h78, 0, 1, 16'h0078, 0, 0);
    add(8'h12, 0, 0, 16'h0, 0, 0);
    add(8'h34, 1, 1, 16'h1234, 1, 1);
    // frame 3: nine items across two groups
    add(8'h00, 0, 0, 16'h0, 0, 0);
    for (int i = 0; i < 8; i++)
      add(8'h30 + 8'(i), 0, 1, 16'h0030 + 16'(i), 0, 0);
    add(8'h80, 0, 0, 16'h0, 0, 0);
    add(8'h01, 0, 0, 16'h0, 0, 0);
    add(8'h02, 1, 1, 16'h0102, 1, 1);

    repeat (3) @(negedge clock);
    check("rst_in_ready", 32'(bus0.in_ready), 32'd0);
    check("rst_valid", 32'(bus0.data_out_valid), 32'd0);
    check("rst_data", 32'(bus0.data_out), 32'd0);
    check("rst_items", 32'(items0), 32'd0);
    check("rst_fmt", 32'(format_error0), 32'd0);
    reset = 1'b1;

    for (int i = 0; i < vecs.size(); i++) begin
      send(vecs[i].b, vecs[i].last);
      if (vecs[i].has_item) begin
        get_item(vecs[i].exp_data, vecs[i].exp_copy, vecs[i].exp_last, $sformatf("vec%0d", i), wc);
        if (i == 1) check("literal_latency", 32'(wc), 32'd0);
      end
    end
    @(negedge clock);
    @(negedge clock);
    check("table_items", 32'(items0), 32'd19);
    check("table_frames", 32'(fd_cnt), 32'd3);

    // busy held for five cycles while an item is presented
    send(8'h00, 0);
    send(8'h7A, 0);
    bus0.decompressor_busy = 1'b1;
    for (int k = 0; k < 5; k++) begin
      @(negedge clock);
      check("busy_valid", 32'(bus0.data_out_valid), 32'd1);
      check("busy_data", 32'(bus0.data_out), 32'h007A);
    end
    bus0.decompressor_busy = 1'b0;
    @(negedge clock);
    check("gap_valid", 32'(bus0.data_out_valid), 32'd0);
    check("gap_ready", 32'(bus0.in_ready), 32'd0);
    check("gap_items", 32'(items0), 32'd20);
    @(negedge clock);
    check("post_gap_ready", 32'(bus0.in_ready), 32'd1);
    send(8'h79, 1);
    get_item(16'h0079, 0, 1, "busy_next", wc);
    @(negedge clock);
    check("busy_frame_done", 32'(frame_done0), 32'd1);

    // truncated copy token
    send(8'h80, 0);
    send(8'hAB, 1);
    @(negedge clock);
    check("trunc_fmt", 32'(format_error0), 32'd1);
    check("trunc_done", 32'(frame_done0), 32'd1);
    check("trunc_items", 32'(items0), 32'd21);
    send(8'h00, 0);
    send(8'h71, 1);
    get_item(16'h0071, 0, 1, "after_err", wc);
    @(negedge clock);
    check("fmt_sticky", 32'(format_error0), 32'd1);
    check("after_err_items", 32'(items0), 32'd22);

    // control byte carrying in_last
    send(8'hFF, 1);
    @(negedge clock);
    check("ctrl_last_done", 32'(frame_done0), 32'd1);
    check("ctrl_last_ready", 32'(bus0.in_ready), 32'd1);
    @(negedge clock);
    check("ctrl_last_valid", 32'(bus0.data_out_valid), 32'd0);
    check("ctrl_last_items", 32'(items0), 32'd22);
    @(posedge clock);
    #1;
    check("frame_count", 32'(fd_cnt), 32'd7);

    // asynchronous reset in the middle of a group
    send(8'h00, 0);
    send(8'h41, 0);
    get_item(16'h0041, 0, 0, "pre_rst", wc);
    send(8'h55, 0);
    bus0.decompressor_busy = 1'b1;
    @(negedge clock);
    check("pre_rst_valid", 32'(bus0.data_out_valid), 32'd1);
    #2;
    reset = 1'b0;
    #1;
    check("async_valid", 32'(bus0.data_out_valid), 32'd0);
    check("async_data", 32'(bus0.data_out), 32'd0);
    check("async_ready", 32'(bus0.in_ready), 32'd0);
    check("async_items", 32'(items0), 32'd0);
    check("async_fmt", 32'(format_error0), 32'd0);
    @(negedge clock);
    reset = 1'b1;
    bus0.decompressor_busy = 1'b0;
    send(8'h00, 0);
    send(8'h72, 1);
    get_item(16'h0072, 0, 1, "post_rst", wc);
    @(negedge clock);
    check("post_rst_items", 32'(items0), 32'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
